// File: rtl/test_mon_pkg.sv
// test_mon_pkg: shared state encoding, register indices and flag value for the
// riscv-tests status monitor.
package test_mon_pkg;
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } mon_state_t;
   localparam logic [4:0]  REG_TESTNUM = 5'd3;
   localparam logic [4:0]  REG_DONE    = 5'd26;
   localparam logic [4:0]  REG_RESULT  = 5'd27;
   localparam logic [31:0] FLAG_SET    = 32'd1;
endpackage

// File: rtl/test_mon_shadow.sv
// test_mon_shadow: snooped copies of x3, x26 and x27 with same-cycle write forwarding;
// the copies freeze while en is low.
module test_mon_shadow
   import test_mon_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        rd_we_i,
   input  logic [4:0]  rd_waddr_i,
   input  logic [31:0] rd_wdata_i,
   output logic [31:0] x3_q,
   output logic [31:0] x3_fwd,
   output logic [31:0] x26_fwd,
   output logic [31:0] x27_fwd,
   output logic        x26_wr
);
   logic [31:0] x26_q, x27_q;
   logic        x3_wr, x27_wr;
   assign x3_wr   = rd_we_i && (rd_waddr_i == REG_TESTNUM);
   assign x26_wr  = rd_we_i && (rd_waddr_i == REG_DONE);
   assign x27_wr  = rd_we_i && (rd_waddr_i == REG_RESULT);
   assign x3_fwd  = x3_wr  ? rd_wdata_i : x3_q;
   assign x26_fwd = x26_wr ? rd_wdata_i : x26_q;
   assign x27_fwd = x27_wr ? rd_wdata_i : x27_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x3_q  <= '0;
         x26_q <= '0;
         x27_q <= '0;
      end else if (en) begin
         x3_q  <= x3_fwd;
         x26_q <= x26_fwd;
         x27_q <= x27_fwd;
      end
   end
endmodule

// File: rtl/test_status_monitor.sv
// test_status_monitor: snoops register-file writes and latches a sticky riscv-tests
// pass/fail verdict; the RUN-state timeout exists only with TEST_MON_TIMEOUT_EN defined.
module test_status_monitor
   import test_mon_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 5,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_we_i,
   input  logic [4:0]       rd_waddr_i,
   input  logic [31:0]      rd_wdata_i,
   output logic             done_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic             timeout_o,
   output logic [31:0]      fail_testnum_o,
   output logic [CNT_W-1:0] cycle_cnt_o
);
   mon_state_t  state, state_nx;
   logic [31:0] settle_cnt, settle_cnt_nx;
   logic [31:0] x3_q, x3_fwd, x26_fwd, x27_fwd;
   logic        x26_wr, start, settle_end, tmo, verdict_pass;
   logic        done_nx, pass_nx, fail_nx, timeout_nx;
   logic [31:0] testnum_nx;
   logic [CNT_W-1:0] cycle_cnt_nx;
   test_mon_shadow u_shadow (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (state != DONE),
      .rd_we_i    (rd_we_i),
      .rd_waddr_i (rd_waddr_i),
      .rd_wdata_i (rd_wdata_i),
      .x3_q       (x3_q),
      .x3_fwd     (x3_fwd),
      .x26_fwd    (x26_fwd),
      .x27_fwd    (x27_fwd),
      .x26_wr     (x26_wr)
   );
   assign start        = x26_wr && (x26_fwd == FLAG_SET);
   assign settle_end   = settle_cnt == 32'(SETTLE_CYCLES);
   assign verdict_pass = x27_fwd == FLAG_SET;
`ifdef TEST_MON_TIMEOUT_EN
   assign tmo = cycle_cnt_o == CNT_W'(TIMEOUT_CYCLES - 1);
`else
   assign tmo = 1'b0;
`endif
   // the x26 = 1 write outranks a timeout landing on the same edge
   always_comb begin
      state_nx      = (state == RUN)    ? (start ? SETTLE : (tmo ? DONE : RUN)) :
                      (state == SETTLE) ? (settle_end ? DONE : SETTLE) : DONE;
      settle_cnt_nx = (state == SETTLE) ? settle_cnt + 32'd1 : '0;
      cycle_cnt_nx  = (state != DONE && cycle_cnt_o != '1) ? cycle_cnt_o + 1'b1 : cycle_cnt_o;
      done_nx       = done_o;
      pass_nx       = pass_o;
      fail_nx       = fail_o;
      timeout_nx    = timeout_o;
      testnum_nx    = fail_testnum_o;
      if (state == SETTLE && settle_end) begin
         done_nx    = 1'b1;
         pass_nx    = verdict_pass;
         fail_nx    = !verdict_pass;
         testnum_nx = verdict_pass ? '0 : x3_fwd;
      end else if (state == RUN && !start && tmo) begin
         done_nx    = 1'b1;
         fail_nx    = 1'b1;
         timeout_nx = 1'b1;
         testnum_nx = x3_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= RUN;
         settle_cnt     <= '0;
         cycle_cnt_o    <= '0;
         done_o         <= 1'b0;
         pass_o         <= 1'b0;
         fail_o         <= 1'b0;
         timeout_o      <= 1'b0;
         fail_testnum_o <= '0;
      end else begin
         state          <= state_nx;
         settle_cnt     <= settle_cnt_nx;
         cycle_cnt_o    <= cycle_cnt_nx;
         done_o         <= done_nx;
         pass_o         <= pass_nx;
         fail_o         <= fail_nx;
         timeout_o      <= timeout_nx;
         fail_testnum_o <= testnum_nx;
      end
   end
endmodule
